reg_file_sequencer: RTL and testbench

//  Initiator side of the 16x8 register-file port: accepts one 16-bit instruction at a time.
//  For each instruction it drives read addresses RA1/RA2 and captures RD1/RD2.
//  It computes the 8-bit result and drives WA / write data / write_enable to commit it.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/reg_file_sequencer_if.sv | 35 +++
 rtl/alu8.sv | 66 ++++++
 rtl/reg_file_sequencer.sv | 91 +++++++++
 tb/tb_reg_file_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, opcode/state encodings and instruction layout for the register-file sequencer.
package cpu_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_MOV = 4'd6,
        OP_LDI = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } seq_state_t;

    // Instruction word: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
    } instr_t;

    // LDI immediate occupies the two source-register fields.
    function automatic logic [DATA_W-1:0] imm8(input instr_t i);
        return {i.rs1, i.rs2};
    endfunction

endpackage

// File: rtl/reg_file_sequencer_if.sv
// Instruction handshake plus register-file read/write port of the sequencer.
interface reg_file_sequencer_if
    import cpu_pkg::*;
();

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  ra1;
    logic [ADDR_W-1:0]  ra2;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;
    logic [ADDR_W-1:0]  wa;
    logic [DATA_W-1:0]  alu_result;
    logic               write_enable;
    logic               done;
    logic               illegal;
    logic               flag_zero;
    logic               flag_carry;

    // Sequencer side: initiates register-file accesses.
    modport master (
        input  instr_valid, instr, rd1, rd2,
        output instr_ready, ra1, ra2, wa, alu_result, write_enable,
               done, illegal, flag_zero, flag_carry
    );

    // Environment side: instruction source and register file.
    modport slave (
        output instr_valid, instr, rd1, rd2,
        input  instr_ready, ra1, ra2, wa, alu_result, write_enable,
               done, illegal, flag_zero, flag_carry
    );

endinterface

// File: rtl/alu8.sv
// Combinational 8-bit ALU: result, carry and write/illegal classification per opcode.
module alu8
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              writes,
    output logic              illegal
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // Carry defaults to the current flag so ops that do not touch it pass it through.
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        result    = '0;
        carry_out = carry_in;
        writes    = 1'b1;
        illegal   = 1'b0;
        case (op)
            OP_NOP: writes = 1'b0;
            OP_ADD: begin
                result    = sum[DATA_W-1:0];
                carry_out = sum[DATA_W];
            end
            OP_SUB: begin
                result    = diff[DATA_W-1:0];
                carry_out = diff[DATA_W];
            end
            OP_AND: begin
                result    = a & b;
                carry_out = 1'b0;
            end
            OP_OR: begin
                result    = a | b;
                carry_out = 1'b0;
            end
            OP_XOR: begin
                result    = a ^ b;
                carry_out = 1'b0;
            end
            OP_MOV: result = a;
            OP_LDI: result = imm;
            OP_SHL: begin
                result    = {a[DATA_W-2:0], 1'b0};
                carry_out = a[DATA_W-1];
            end
            OP_SHR: begin
                result    = {1'b0, a[DATA_W-1:1]};
                carry_out = a[0];
            end
            default: begin
                writes  = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/reg_file_sequencer.sv
// Fetches operands from the register file, executes one instruction and writes the result back.
module reg_file_sequencer
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    reg_file_sequencer_if.master bus
);

    seq_state_t        state;
    instr_t            instr_q;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    logic [DATA_W-1:0] imm_c;
    logic [DATA_W-1:0] alu_res_c;
    logic              alu_carry_c;
    logic              alu_writes_c;
    logic              alu_illegal_c;

    assign imm_c = imm8(instr_q);

    alu8 u_alu (
        .op        (instr_q.opcode),
        .a         (opa),
        .b         (opb),
        .imm       (imm_c),
        .carry_in  (bus.flag_carry),
        .result    (alu_res_c),
        .carry_out (alu_carry_c),
        .writes    (alu_writes_c),
        .illegal   (alu_illegal_c)
    );

    // IDLE -> READ -> EXEC -> WB sequencing with registered port outputs; pulses last one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            instr_q          <= '0;
            opa              <= '0;
            opb              <= '0;
            bus.instr_ready  <= 1'b1;
            bus.ra1          <= '0;
            bus.ra2          <= '0;
            bus.wa           <= '0;
            bus.alu_result   <= '0;
            bus.write_enable <= 1'b0;
            bus.done         <= 1'b0;
            bus.illegal      <= 1'b0;
            bus.flag_zero    <= 1'b0;
            bus.flag_carry   <= 1'b0;
        end else begin
            bus.write_enable <= 1'b0;
            bus.done         <= 1'b0;
            bus.illegal      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid && bus.instr_ready) begin
                        instr_q         <= instr_t'(bus.instr);
                        bus.ra1         <= bus.instr[7:4];
                        bus.ra2         <= bus.instr[3:0];
                        bus.instr_ready <= 1'b0;
                        state           <= S_READ;
                    end
                end
                S_READ: begin
                    opa   <= bus.rd1;
                    opb   <= bus.rd2;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    bus.wa           <= instr_q.rd;
                    bus.write_enable <= alu_writes_c;
                    bus.done         <= 1'b1;
                    bus.illegal      <= alu_illegal_c;
                    bus.flag_carry   <= alu_carry_c;
                    if (alu_writes_c) begin
                        bus.alu_result <= alu_res_c;
                        bus.flag_zero  <= (alu_res_c == '0);
                    end
                    state <= S_WB;
                end
                S_WB: begin
                    bus.instr_ready <= 1'b1;
                    state           <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Bench: sequencer in front of a behavioural 16x8 register file, checked against an ISA-level model.
module tb_reg_file_sequencer;

    logic clk;
    logic reset_n;

    reg_file_sequencer_if bus ();

    reg_file_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational read, write on rising edge.
    logic [7:0] rf [16];
    assign bus.rd1 = rf[bus.ra1];
    assign bus.rd2 = rf[bus.ra2];
    always @(posedge clk) if (bus.write_enable) rf[bus.wa] <= bus.alu_result;

    int n_cmp = 0;
    int n_bad = 0;

    // ISA-level reference state.
    logic [7:0] mdl_rf [16];
    bit         mdl_zero;
    bit         mdl_carry;

    typedef struct {
        int         done_k;
        int         done_cnt;
        int         we_cnt;
        int         ill_cnt;
        int         ready_low;
        int         wait_cyc;
        logic       ill_at_done;
        logic [3:0] wa;
        logic [7:0] res;
        logic       zero;
        logic       carry;
    } obs_t;

    typedef struct {
        bit         we;
        bit         ill;
        logic [7:0] res;
        bit         zero;
        bit         carry;
    } exp_t;

    function automatic logic [15:0] enc(input int op, input int rd, input int a, input int b);
        return {4'(op), 4'(rd), 4'(a), 4'(b)};
    endfunction

    function automatic logic [15:0] ldi(input int rd, input int imm);
        return {4'd7, 4'(rd), 8'(imm)};
    endfunction

    // Architectural effect of one instruction, in plain integer arithmetic.
    task automatic model_step(input logic [15:0] ins, output exp_t e);
        int op, x, y, r;
        op = int'(ins[15:12]);
        x  = int'(mdl_rf[ins[7:4]]);
        y  = int'(mdl_rf[ins[3:0]]);
        r  = 0;
        e.we  = 1'b1;
        e.ill = 1'b0;
        case (op)
            0: e.we = 1'b0;
            1: begin r = x + y; mdl_carry = (r > 255); end
            2: begin r = x - y; mdl_carry = (x < y); end
            3: begin r = x & y; mdl_carry = 1'b0; end
            4: begin r = x | y; mdl_carry = 1'b0; end
            5: begin r = x ^ y; mdl_carry = 1'b0; end
            6: r = x;
            7: r = int'(ins[7:0]);
            8: begin r = x * 2; mdl_carry = (x >= 128); end
            9: begin r = x / 2; mdl_carry = ((x % 2) == 1); end
            default: begin e.we = 1'b0; e.ill = 1'b1; end
        endcase
        r = ((r % 256) + 256) % 256;
        e.res = 8'(r);
        if (e.we) begin
            mdl_rf[ins[11:8]] = 8'(r);
            mdl_zero = (r == 0);
        end
        e.zero  = mdl_zero;
        e.carry = mdl_carry;
    endtask

    // Offer one instruction (called at a negedge) and record what the port does until IDLE returns.
    task automatic issue(input logic [15:0] ins, input bit keep, output obs_t o);
        o = '{default: 0};
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && o.wait_cyc < 8) begin
            @(negedge clk);
            o.wait_cyc++;
        end
        if (!bus.instr_ready) begin
            bus.instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) bus.instr_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            if (!bus.instr_ready) o.ready_low++;
            if (bus.write_enable) o.we_cnt++;
            if (bus.illegal) o.ill_cnt++;
            if (bus.done) begin
                o.done_cnt++;
                if (o.done_k == 0) begin
                    o.done_k      = k;
                    o.wa          = bus.wa;
                    o.res         = bus.alu_result;
                    o.zero        = bus.flag_zero;
                    o.carry       = bus.flag_carry;
                    o.ill_at_done = bus.illegal;
                end
            end
            if (bus.instr_ready) break;
        end
    endtask

    task automatic run(input logic [15:0] ins, input bit keep, output obs_t o, output exp_t e);
        model_step(ins, e);
        issue(ins, keep, o);
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.instr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.instr_ready); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.write_enable !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", bus.write_enable); end
        n_cmp++; if (bus.illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal: got %b want 0", bus.illegal); end
        n_cmp++; if ({bus.flag_zero, bus.flag_carry} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b%b want 00", bus.flag_zero, bus.flag_carry); end
        n_cmp++; if ({bus.ra1, bus.ra2, bus.wa, bus.alu_result} !== 20'h0) begin n_bad++; $display("FAIL reset_addr_data: got %h want 0", {bus.ra1, bus.ra2, bus.wa, bus.alu_result}); end
        reset_n   = 1'b1;
        mdl_zero  = 1'b0;
        mdl_carry = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ldi_add();
        obs_t o; exp_t e;
        run(ldi(3, 8'h7F), 1'b0, o, e);
        n_cmp++; if (o.done_k !== 3) begin n_bad++; $display("FAIL ldi3_latency: got %0d want 3", o.done_k); end
        n_cmp++; if ({o.wa, o.res} !== {4'd3, 8'h7F} || o.we_cnt !== 1) begin n_bad++; $display("FAIL ldi3_write: got wa=%h res=%h we=%0d want 3/7f/1", o.wa, o.res, o.we_cnt); end
        run(ldi(4, 8'h01), 1'b0, o, e);
        n_cmp++; if (o.done_k !== 3) begin n_bad++; $display("FAIL ldi4_latency: got %0d want 3", o.done_k); end
        run(enc(1, 5, 3, 4), 1'b0, o, e);
        n_cmp++; if (o.done_k !== 3 || o.done_cnt !== 1) begin n_bad++; $display("FAIL add5_latency: got k=%0d n=%0d want 3/1", o.done_k, o.done_cnt); end
        n_cmp++; if ({o.wa, o.res} !== {4'd5, 8'h80}) begin n_bad++; $display("FAIL add5_result: got wa=%h res=%h want 5/80", o.wa, o.res); end
        n_cmp++; if ({o.zero, o.carry} !== 2'b00) begin n_bad++; $display("FAIL add5_flags: got z=%b c=%b want 0/0", o.zero, o.carry); end
        n_cmp++; if (rf[5] !== 8'h80) begin n_bad++; $display("FAIL add5_rf: got %h want 80", rf[5]); end
    endtask

    task automatic test_add_carry();
        obs_t o; exp_t e;
        run(ldi(1, 8'hFF), 1'b0, o, e);
        run(ldi(2, 8'h01), 1'b0, o, e);
        run(enc(1, 6, 1, 2), 1'b0, o, e);
        n_cmp++; if (o.res !== 8'h00 || rf[6] !== 8'h00) begin n_bad++; $display("FAIL addc_result: got res=%h rf=%h want 00", o.res, rf[6]); end
        n_cmp++; if ({o.zero, o.carry} !== 2'b11) begin n_bad++; $display("FAIL addc_flags: got z=%b c=%b want 1/1", o.zero, o.carry); end
    endtask

    task automatic test_sub_and();
        obs_t o; exp_t e;
        run(ldi(1, 8'h03), 1'b0, o, e);
        run(ldi(2, 8'h05), 1'b0, o, e);
        run(enc(2, 7, 1, 2), 1'b0, o, e);
        n_cmp++; if (o.res !== 8'hFE || rf[7] !== 8'hFE) begin n_bad++; $display("FAIL sub_result: got res=%h rf=%h want fe", o.res, rf[7]); end
        n_cmp++; if ({o.zero, o.carry} !== 2'b01) begin n_bad++; $display("FAIL sub_flags: got z=%b c=%b want 0/1", o.zero, o.carry); end
        run(enc(3, 7, 7, 7), 1'b0, o, e);
        n_cmp++; if (o.res !== 8'hFE || o.carry !== 1'b0) begin n_bad++; $display("FAIL and_clear: got res=%h c=%b want fe/0", o.res, o.carry); end
    endtask

    task automatic test_illegal();
        obs_t o; exp_t e;
        run(ldi(1, 8'hFF), 1'b0, o, e);
        run(ldi(2, 8'h01), 1'b0, o, e);
        run(enc(1, 9, 1, 2), 1'b0, o, e);
        run(enc(12, 9, 1, 2), 1'b0, o, e);
        n_cmp++; if (o.done_cnt !== 1 || o.ill_cnt !== 1 || o.ill_at_done !== 1'b1) begin n_bad++; $display("FAIL ill_pulse: got done=%0d ill=%0d with=%b want 1/1/1", o.done_cnt, o.ill_cnt, o.ill_at_done); end
        n_cmp++; if (o.we_cnt !== 0) begin n_bad++; $display("FAIL ill_nowrite: got we=%0d want 0", o.we_cnt); end
        n_cmp++; if ({o.zero, o.carry} !== 2'b11 || rf[9] !== 8'h00) begin n_bad++; $display("FAIL ill_hold: got z=%b c=%b rf9=%h want 1/1/00", o.zero, o.carry, rf[9]); end
    endtask

    task automatic test_back_to_back();
        obs_t o; exp_t e;
        run(ldi(1, 8'h03), 1'b0, o, e);
        run(enc(1, 1, 1, 1), 1'b1, o, e);
        n_cmp++; if (o.res !== 8'h06 || o.ready_low !== 3 || o.done_cnt !== 1) begin n_bad++; $display("FAIL b2b_first: got res=%h busy=%0d done=%0d want 06/3/1", o.res, o.ready_low, o.done_cnt); end
        run(enc(1, 1, 1, 1), 1'b0, o, e);
        n_cmp++; if (o.res !== 8'h0C || o.ready_low !== 3 || o.wait_cyc !== 0) begin n_bad++; $display("FAIL b2b_second: got res=%h busy=%0d wait=%0d want 0c/3/0", o.res, o.ready_low, o.wait_cyc); end
        n_cmp++; if (rf[1] !== 8'h0C) begin n_bad++; $display("FAIL b2b_rf: got %h want 0c", rf[1]); end
    endtask

    task automatic test_mid_reset();
        obs_t o; exp_t e;
        int we_seen;
        run(ldi(2, 8'h55), 1'b0, o, e);
        bus.instr       = ldi(2, 8'hAA);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.write_enable !== 1'b0 || bus.instr_ready !== 1'b1 || bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_outputs: got we=%b rdy=%b done=%b want 0/1/0", bus.write_enable, bus.instr_ready, bus.done); end
        mdl_zero  = 1'b0;
        mdl_carry = 1'b0;
        we_seen   = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.write_enable) we_seen++;
        end
        n_cmp++; if (rf[2] !== 8'h55 || we_seen !== 0) begin n_bad++; $display("FAIL rst_mid_nowrite: got rf2=%h we=%0d want 55/0", rf[2], we_seen); end
        run(ldi(2, 8'hAA), 1'b0, o, e);
        n_cmp++; if (rf[2] !== 8'hAA || o.done_k !== 3) begin n_bad++; $display("FAIL rst_mid_resume: got rf2=%h k=%0d want aa/3", rf[2], o.done_k); end
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        logic [15:0] ins;
        int rd, n;
        for (int r = 0; r < 16; r++) run(ldi(r, $urandom_range(0, 255)), 1'b0, o, e);
        n = 60;
        for (int i = 0; i < n; i++) begin
            rd  = $urandom_range(0, 15);
            ins = enc($urandom_range(0, 15), rd, $urandom_range(0, 15), $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ins = enc(int'(ins[15:12]), rd, rd, rd);
            if (ins[15:12] == 4'd7 && $urandom_range(0, 3) == 0) ins[7:0] = 8'h00;
            run(ins, (i < n - 1) && ($urandom_range(0, 1) == 1), o, e);
            n_cmp++; if (o.done_k !== 3 || o.done_cnt !== 1) begin n_bad++; $display("FAIL rnd_latency[%0d] %h: got k=%0d n=%0d want 3/1", i, ins, o.done_k, o.done_cnt); end
            n_cmp++; if (o.we_cnt !== int'(e.we) || o.ill_cnt !== int'(e.ill)) begin n_bad++; $display("FAIL rnd_class[%0d] %h: got we=%0d ill=%0d want %0d/%0d", i, ins, o.we_cnt, o.ill_cnt, e.we, e.ill); end
            n_cmp++; if ({o.zero, o.carry} !== {e.zero, e.carry}) begin n_bad++; $display("FAIL rnd_flags[%0d] %h: got z=%b c=%b want %b/%b", i, ins, o.zero, o.carry, e.zero, e.carry); end
            if (e.we) begin
                n_cmp++; if ({o.wa, o.res} !== {4'(rd), e.res} || rf[rd] !== mdl_rf[rd]) begin n_bad++; $display("FAIL rnd_write[%0d] %h: got wa=%h res=%h rf=%h want %h/%h", i, ins, o.wa, o.res, rf[rd], 4'(rd), e.res); end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n         = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        test_reset();
        test_ldi_add();
        test_add_carry();
        test_sub_and();
        test_illegal();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
